fft_bar_scheduler: RTL and testbench
====================================

Name: fft_bar_scheduler

Overview:
- Sequences the shared magnitude-to-bar converter (Start/Busy/End handshake, 7-bit result) for the stereo analyzer.
- When the FFT for a channel (L or R) has written its magnitude buffer, it raises a request. The block arbitrates between the two channels round-robin and walks every bin of the granted channel.
- For each bin it reads the magnitude, runs one conversion and writes the 7-bit bar height into the bar RAM at address {ch, bin}.
- It sits between the FFT magnitude buffers, the converter and the display bar RAM.

Parameters:
- bw_input, 17: magnitude width; equals the converter input width.
- bw_bin, 5: bin index width.
- num_bins, 32: bins per frame; must be ≤ 2^bw_bin.
- bw_tmo, 6: timeout counter width; timeout limit is 2^bw_tmo−1 cycles.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous active-high reset.
- ReqL  in  1  one-cycle pulse: L magnitude frame ready.
- ReqR  in  1  one-cycle pulse: R magnitude frame ready.
- MagRdCh  out  1  channel select for the magnitude read (0=L, 1=R).
- MagRdAddr  out  bw_bin  bin address for the magnitude read.
- MagRdData  in  bw_input  magnitude; valid exactly 1 cycle after the address.
- ConvStart  out  1  one-cycle start pulse to the converter.
- ConvIn  out  bw_input  converter operand; held stable from ConvStart until End.
- ConvOut  in  7  converter result; valid when ConvEnd=1.
- ConvEnd  in  1  converter done pulse.
- ConvBusy  in  1  converter busy.
- BarWe  out  1  bar RAM write enable, one-cycle pulse.
- BarAddr  out  bw_bin+1  write address {ch, bin}.
- BarData  out  7  bar height.
- Busy  out  1  a frame is in progress.
- FrameDone  out  1  one-cycle pulse after the last bin of a frame is written.
- DoneCh  out  1  channel of the finished frame; valid with FrameDone.
- TmoErr  out  1  sticky timeout flag; cleared only by Reset.

Behaviour:
- Reset: all outputs 0, pending flags 0, RR pointer=L, state IDLE. Reset mid-frame abandons the frame; ConvStart is 0 from the reset edge onward.
- Pending latches:
  - pendL is set by ReqL and cleared on the cycle L is granted.
  - A ReqL arriving on the grant cycle or during an L frame sets pendL again, so the frame is reprocessed afterwards.
  - Repeated ReqL pulses merge into one pending request. R behaves identically.
- Arbitration (ARB state):
  - Only one flag pending → grant that channel.
  - Both pending → grant the channel the RR pointer indicates. The pointer toggles to the other channel after every grant.
- States:
  - IDLE: Busy=0. Go to ARB when any flag is pending.
  - ARB: latch ch, set bin=0, Busy=1. Go to RD.
  - RD: drive MagRdCh=ch, MagRdAddr=bin. Go to CAP.
  - CAP: register MagRdData into ConvIn. Go to LAUNCH.
  - LAUNCH: wait while ConvBusy=1. When ConvBusy=0, pulse ConvStart for 1 cycle, clear the timeout counter and go to WAIT. ConvEnd is ignored in this state.
  - WAIT: the counter increments each cycle.
    - ConvEnd=1 → capture ConvOut into BarData and go to WR.
    - Counter reaches 2^bw_tmo−1 → set BarData=0 and TmoErr=1, go to WR.
    - ConvEnd and timeout on the same cycle → ConvEnd wins.
  - WR: BarWe=1 with BarAddr={ch, bin}.
    - bin==num_bins−1 → go to DONE.
    - Otherwise bin+1 and go to RD.
  - DONE: FrameDone=1 and DoneCh=ch for 1 cycle. Go to ARB if any flag is pending, else IDLE.
- ConvIn is held unchanged from CAP until the next CAP. The converter evaluates saturation combinationally on its input throughout the conversion.
- Per-bin latency is RD→CAP→LAUNCH→(k WAIT cycles)→WR, i.e. 4+k cycles with no busy stall. A saturating operand gives k=1.
- BarData, BarAddr and MagRdCh/MagRdAddr are registered outputs. BarWe, ConvStart and FrameDone are registered pulses, exactly 1 cycle wide.
- bin never wraps past num_bins−1. num_bins < 2^bw_bin is legal.

Decomposition:
- Package fft_bar_pkg:
  - state enum (IDLE, ARB, RD, CAP, LAUNCH, WAIT, WR, DONE);
  - channel constants CH_L=0, CH_R=1;
  - bar width 7;
  - timeout fill value 0.
- Sub-module bar_ch_arbiter: two pending latches, RR pointer and grant logic, with inputs ReqL/ReqR/grant_take and outputs pend_any/grant_ch.

Test Plan:
- ReqL only; converter model gives End 3 cycles after Start with Out=bin+10 → 32 writes to addresses 0..31 with data 10..41. FrameDone with DoneCh=0 arrives 1 cycle after the write to address 31. Each bin takes 4+3 cycles.
- ReqL and ReqR on the same cycle after reset → L frame runs first, then R (addresses 32..63). A following simultaneous pair is granted R first.
- ReqR pulsed mid-way through an R frame, at bin 10 → the frame completes, then one more R frame runs. Two FrameDone pulses, both DoneCh=1.
- Converter never asserts End for bin 5 → after 63 WAIT cycles BarData=0 is written to address 5 and TmoErr=1 stays high. Bins 6..31 proceed normally.
- ConvBusy held high for 4 cycles in LAUNCH → ConvStart is delayed until ConvBusy falls. ConvIn stays stable from CAP until ConvEnd.
- Reset asserted during WAIT of bin 17 → all outputs are 0 immediately and no BarWe follows. A new ReqL after release restarts at bin 0.

Source files
------------

// File: rtl/fft_bar_pkg.sv
// Shared types and constants for the stereo analyzer bar scheduler.
package fft_bar_pkg;

    localparam int BAR_W = 7;

    // Bar height written when the converter never reports completion.
    localparam logic [BAR_W-1:0] TMO_FILL = '0;

    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_RD     = 3'd2,
        ST_CAP    = 3'd3,
        ST_LAUNCH = 3'd4,
        ST_WAIT   = 3'd5,
        ST_WR     = 3'd6,
        ST_DONE   = 3'd7
    } state_e;

endpackage

// File: rtl/fft_bar_scheduler_arbiter.sv
// Round-robin channel arbiter: one pending latch per channel plus the RR pointer.
module bar_ch_arbiter
    import fft_bar_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic ReqL,
    input  logic ReqR,
    input  logic grant_take,
    output logic pend_any,
    output logic grant_ch
);

    logic pend_l_q, pend_l_d;
    logic pend_r_q, pend_r_d;
    logic rr_q, rr_d;

    // Grant selection and next values of the pending latches and the RR pointer.
    always_comb begin
        pend_any = pend_l_q | pend_r_q;

        if (pend_l_q && pend_r_q) begin
            grant_ch = rr_q;
        end else if (pend_r_q) begin
            grant_ch = CH_R;
        end else begin
            grant_ch = CH_L;
        end

        pend_l_d = pend_l_q;
        pend_r_d = pend_r_q;
        rr_d     = rr_q;

        // A grant clears its own latch and points the RR pointer at the other channel.
        if (grant_take) begin
            if (grant_ch == CH_L) begin
                pend_l_d = 1'b0;
            end else begin
                pend_r_d = 1'b0;
            end
            rr_d = ~grant_ch;
        end

        // A request on the grant cycle wins over the clear so the frame is redone later.
        if (ReqL) begin
            pend_l_d = 1'b1;
        end
        if (ReqR) begin
            pend_r_d = 1'b1;
        end
    end

    // Pending latches and RR pointer; pointer starts at L.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pend_l_q <= 1'b0;
            pend_r_q <= 1'b0;
            rr_q     <= CH_L;
        end else begin
            pend_l_q <= pend_l_d;
            pend_r_q <= pend_r_d;
            rr_q     <= rr_d;
        end
    end

endmodule

// File: rtl/fft_bar_scheduler.sv
// Walks every bin of a granted channel: read magnitude, convert, write bar height.
//
// Converter handshake: ConvStart is a one-cycle pulse issued only while
// ConvBusy is low; ConvIn is held from CAP until the next CAP; the converter
// reports completion with a one-cycle ConvEnd carrying ConvOut. ConvEnd is only
// honoured in WAIT, and a missing ConvEnd is bounded by the timeout counter.
module fft_bar_scheduler
    import fft_bar_pkg::*;
#(
    parameter int bw_input = 17,
    parameter int bw_bin   = 5,
    parameter int num_bins = 32,
    parameter int bw_tmo   = 6
)(
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ReqL,
    input  logic                ReqR,
    output logic                MagRdCh,
    output logic [bw_bin-1:0]   MagRdAddr,
    input  logic [bw_input-1:0] MagRdData,
    output logic                ConvStart,
    output logic [bw_input-1:0] ConvIn,
    input  logic [BAR_W-1:0]    ConvOut,
    input  logic                ConvEnd,
    input  logic                ConvBusy,
    output logic                BarWe,
    output logic [bw_bin:0]     BarAddr,
    output logic [BAR_W-1:0]    BarData,
    output logic                Busy,
    output logic                FrameDone,
    output logic                DoneCh,
    output logic                TmoErr,
    output state_e              dbg_state
);

    localparam logic [bw_bin-1:0] LAST_BIN  = bw_bin'(num_bins - 1);
    localparam logic [bw_tmo-1:0] TMO_LIMIT = '1;

    state_e                state_q, state_d;
    logic                  ch_q, ch_d;
    logic [bw_bin-1:0]     bin_q, bin_d;
    logic [bw_tmo-1:0]     tmo_q, tmo_d;
    logic [bw_input-1:0]   conv_in_q, conv_in_d;
    logic                  conv_start_q, conv_start_d;
    logic                  mag_rd_ch_q, mag_rd_ch_d;
    logic [bw_bin-1:0]     mag_rd_addr_q, mag_rd_addr_d;
    logic                  bar_we_q, bar_we_d;
    logic [bw_bin:0]       bar_addr_q, bar_addr_d;
    logic [BAR_W-1:0]      bar_data_q, bar_data_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  done_ch_q, done_ch_d;
    logic                  tmo_err_q, tmo_err_d;

    logic                  pend_any;
    logic                  grant_ch;
    logic                  grant_take;

    bar_ch_arbiter u_arb (
        .Clock      (Clock),
        .Reset      (Reset),
        .ReqL       (ReqL),
        .ReqR       (ReqR),
        .grant_take (grant_take),
        .pend_any   (pend_any),
        .grant_ch   (grant_ch)
    );

    // Next-state and registered-output logic; pulses default low every cycle.
    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        bin_d         = bin_q;
        tmo_d         = tmo_q;
        conv_in_d     = conv_in_q;
        conv_start_d  = 1'b0;
        mag_rd_ch_d   = mag_rd_ch_q;
        mag_rd_addr_d = mag_rd_addr_q;
        bar_we_d      = 1'b0;
        bar_addr_d    = bar_addr_q;
        bar_data_d    = bar_data_q;
        frame_done_d  = 1'b0;
        done_ch_d     = done_ch_q;
        tmo_err_d     = tmo_err_q;
        grant_take    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_any) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                grant_take    = 1'b1;
                ch_d          = grant_ch;
                bin_d         = '0;
                mag_rd_ch_d   = grant_ch;
                mag_rd_addr_d = '0;
                state_d       = ST_RD;
            end
            ST_RD: begin
                // Read address is already on MagRdCh/MagRdAddr; data returns next cycle.
                state_d = ST_CAP;
            end
            ST_CAP: begin
                conv_in_d = MagRdData;
                state_d   = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                if (!ConvBusy) begin
                    conv_start_d = 1'b1;
                    tmo_d        = '0;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (ConvEnd) begin
                    bar_data_d = ConvOut;
                    bar_we_d   = 1'b1;
                    bar_addr_d = {ch_q, bin_q};
                    state_d    = ST_WR;
                end else if (tmo_d == TMO_LIMIT) begin
                    bar_data_d = TMO_FILL;
                    tmo_err_d  = 1'b1;
                    bar_we_d   = 1'b1;
                    bar_addr_d = {ch_q, bin_q};
                    state_d    = ST_WR;
                end
            end
            ST_WR: begin
                if (bin_q == LAST_BIN) begin
                    frame_done_d = 1'b1;
                    done_ch_d    = ch_q;
                    state_d      = ST_DONE;
                end else begin
                    bin_d         = bin_q + 1'b1;
                    mag_rd_addr_d = bin_q + 1'b1;
                    state_d       = ST_RD;
                end
            end
            ST_DONE: begin
                state_d = pend_any ? ST_ARB : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            ch_q          <= CH_L;
            bin_q         <= '0;
            tmo_q         <= '0;
            conv_in_q     <= '0;
            conv_start_q  <= 1'b0;
            mag_rd_ch_q   <= 1'b0;
            mag_rd_addr_q <= '0;
            bar_we_q      <= 1'b0;
            bar_addr_q    <= '0;
            bar_data_q    <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            done_ch_q     <= 1'b0;
            tmo_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            bin_q         <= bin_d;
            tmo_q         <= tmo_d;
            conv_in_q     <= conv_in_d;
            conv_start_q  <= conv_start_d;
            mag_rd_ch_q   <= mag_rd_ch_d;
            mag_rd_addr_q <= mag_rd_addr_d;
            bar_we_q      <= bar_we_d;
            bar_addr_q    <= bar_addr_d;
            bar_data_q    <= bar_data_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            done_ch_q     <= done_ch_d;
            tmo_err_q     <= tmo_err_d;
        end
    end

    assign MagRdCh   = mag_rd_ch_q;
    assign MagRdAddr = mag_rd_addr_q;
    assign ConvStart = conv_start_q;
    assign ConvIn    = conv_in_q;
    assign BarWe     = bar_we_q;
    assign BarAddr   = bar_addr_q;
    assign BarData   = bar_data_q;
    assign Busy      = busy_q;
    assign FrameDone = frame_done_q;
    assign DoneCh    = done_ch_q;
    assign TmoErr    = tmo_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fft_bar_scheduler.sv
// Directed bench for fft_bar_scheduler with magnitude-buffer and converter models.
module tb_fft_bar_scheduler;
    import fft_bar_pkg::*;

    localparam int BW_INPUT = 17;
    localparam int BW_BIN   = 5;
    localparam int NUM_BINS = 32;
    localparam int CONV_K   = 3;   // WAIT cycles per conversion, Start cycle counted

    // ---------------- clock / reset ----------------
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    logic                ReqL = 1'b0;
    logic                ReqR = 1'b0;
    logic                MagRdCh;
    logic [BW_BIN-1:0]   MagRdAddr;
    logic [BW_INPUT-1:0] MagRdData = '0;
    logic                ConvStart;
    logic [BW_INPUT-1:0] ConvIn;
    logic [6:0]          ConvOut = '0;
    logic                ConvEnd = 1'b0;
    logic                ConvBusy;
    logic                BarWe;
    logic [BW_BIN:0]     BarAddr;
    logic [6:0]          BarData;
    logic                Busy;
    logic                FrameDone;
    logic                DoneCh;
    logic                TmoErr;
    state_e              dbg_state;

    fft_bar_scheduler dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .ReqL      (ReqL),
        .ReqR      (ReqR),
        .MagRdCh   (MagRdCh),
        .MagRdAddr (MagRdAddr),
        .MagRdData (MagRdData),
        .ConvStart (ConvStart),
        .ConvIn    (ConvIn),
        .ConvOut   (ConvOut),
        .ConvEnd   (ConvEnd),
        .ConvBusy  (ConvBusy),
        .BarWe     (BarWe),
        .BarAddr   (BarAddr),
        .BarData   (BarData),
        .Busy      (Busy),
        .FrameDone (FrameDone),
        .DoneCh    (DoneCh),
        .TmoErr    (TmoErr),
        .dbg_state (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Magnitude encodes {ch, 000, bin, 0x5A} so the converter model can recover ch and bin.
    function automatic logic [BW_INPUT-1:0] mag_of(input logic ch, input logic [4:0] bin);
        return {ch, 3'b000, bin, 8'h5A};
    endfunction

    // Bar height for a bin: bin+10 on L, bin+60 on R.
    function automatic logic [6:0] exp_bar(input logic ch, input logic [4:0] bin);
        return 7'(bin) + 7'd10 + (ch ? 7'd50 : 7'd0);
    endfunction

    // ---------------- environment models ----------------
    logic       hang_en    = 1'b0;
    logic [4:0] hang_bin   = 5'd0;
    logic       force_busy = 1'b0;
    logic [3:0] rem        = '0;

    always @(posedge Clock) begin
        MagRdData <= mag_of(MagRdCh, MagRdAddr);
    end

    always @(posedge Clock) begin
        ConvEnd <= 1'b0;
        if (Reset) begin
            rem <= '0;
        end else begin
            if (rem != 0) rem <= rem - 1'b1;
            if (rem == 4'd1) begin
                ConvEnd <= 1'b1;
                ConvOut <= exp_bar(ConvIn[16], ConvIn[12:8]);
            end
            if (ConvStart && !(hang_en && ConvIn[12:8] == hang_bin))
                rem <= 4'(CONV_K - 2);
        end
    end

    assign ConvBusy = (rem != 0) || force_busy;

    // ---------------- scoreboard ----------------
    // entry = {gap from previous write (0 = unchecked), addr[5:0], data[6:0]}
    logic [20:0] exp_q[$];
    logic        done_q[$];
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          frames_done = 0;
    logic [BW_INPUT-1:0] held_in = '0;
    logic        in_flight = 1'b0;

    initial begin
        forever begin
            @(negedge Clock);
            cyc++;
            if (Reset) in_flight = 1'b0;
            if (ConvStart) begin
                held_in   = ConvIn;
                in_flight = 1'b1;
            end
            if (ConvEnd && in_flight) begin
                check("conv_in_hold", 64'(ConvIn), 64'(held_in));
                in_flight = 1'b0;
            end
            if (BarWe) begin
                if (exp_q.size() == 0) begin
                    check("bar_we_unexpected", 64'(BarWe), 64'(0));
                end else begin
                    logic [20:0] e;
                    e = exp_q.pop_front();
                    check("bar_addr", 64'(BarAddr), 64'(e[12:7]));
                    check("bar_data", 64'(BarData), 64'(e[6:0]));
                    if (e[20:13] != 0) check("bin_gap", 64'(cyc - last_wr_cyc), 64'(e[20:13]));
                end
                last_wr_cyc = cyc;
            end
            if (FrameDone) begin
                if (done_q.size() == 0) begin
                    check("frame_done_unexpected", 64'(FrameDone), 64'(0));
                end else begin
                    logic dch;
                    dch = done_q.pop_front();
                    check("done_ch", 64'(DoneCh), 64'(dch));
                    check("done_latency", 64'(cyc - last_wr_cyc), 64'(1));
                end
                frames_done++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_frame(input logic ch, input int hbin, input int sbin);
        for (int b = 0; b < NUM_BINS; b++) begin
            logic [7:0] gap;
            logic [6:0] d;
            logic [4:0] b5;
            b5  = b[4:0];
            gap = (b == 0) ? 8'd0 : (b == hbin) ? 8'd67 : (b == sbin) ? 8'd11 : 8'd7;
            d   = (b == hbin) ? 7'd0 : exp_bar(ch, b5);
            exp_q.push_back({gap, ch, b5, d});
        end
        done_q.push_back(ch);
    endtask

    task automatic pulse_req(input logic l, input logic r);
        ReqL = l;
        ReqR = r;
        @(negedge Clock);
        ReqL = 1'b0;
        ReqR = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {MagRdCh, MagRdAddr, ConvStart, ConvIn, BarWe, BarAddr, BarData,
                    Busy, FrameDone, DoneCh, TmoErr}, 64'(0));
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        ReqL  = 1'b0;
        ReqR  = 1'b0;
        exp_q.delete();
        done_q.delete();
        repeat (3) @(negedge Clock);
        check_outputs_zero("reset_outputs");
        Reset = 1'b0;
        @(negedge Clock);
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int target;
        int i;
        target = frames_done + n;
        i = 0;
        while (frames_done < target && i < budget) begin
            @(negedge Clock);
            i++;
        end
        check(tag, 64'(frames_done >= target), 64'(1));
        check({tag, "_drained"}, 64'(exp_q.size() + done_q.size()), 64'(0));
    endtask

    task automatic wait_state(input state_e st, input int bin, input int budget, input string tag);
        int i;
        i = 0;
        while (!(dbg_state == st && MagRdAddr == bin[4:0]) && i < budget) begin
            @(negedge Clock);
            i++;
        end
        check(tag, 64'(i < budget), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // L frame alone: data 10..41 at addresses 0..31, 7 cycles per bin.
        do_reset();
        push_frame(CH_L, -1, -1);
        pulse_req(1'b1, 1'b0);
        @(negedge Clock);
        check("arb_busy", 64'(Busy), 64'(1));
        check("arb_state", 64'(dbg_state), 64'(ST_ARB));
        @(negedge Clock);
        check("rd_addr", 64'({MagRdCh, MagRdAddr}), 64'(0));
        wait_frames(1, 400, "s1_frame");
        repeat (2) @(negedge Clock);
        check("s1_idle_busy", 64'(Busy), 64'(0));
        check("s1_tmo_clear", 64'(TmoErr), 64'(0));

        // Simultaneous pair after reset, another pair during the L frame: L, R, L.
        do_reset();
        push_frame(CH_L, -1, -1);
        push_frame(CH_R, -1, -1);
        push_frame(CH_L, -1, -1);
        pulse_req(1'b1, 1'b1);
        repeat (50) @(negedge Clock);
        pulse_req(1'b1, 1'b1);
        wait_frames(3, 1200, "s2_frames");

        // ReqR again at bin 10 of an R frame: two R frames.
        push_frame(CH_R, -1, -1);
        push_frame(CH_R, -1, -1);
        pulse_req(1'b0, 1'b1);
        wait_state(ST_RD, 10, 200, "s3_reach_bin10");
        check("s3_rd_ch", 64'(MagRdCh), 64'(1));
        pulse_req(1'b0, 1'b1);
        wait_frames(2, 800, "s3_frames");

        // Converter hangs on bin 5: zero bar after 63 WAIT cycles, sticky TmoErr.
        hang_bin = 5'd5;
        hang_en  = 1'b1;
        push_frame(CH_L, 5, -1);
        pulse_req(1'b1, 1'b0);
        wait_state(ST_WAIT, 5, 200, "s4_reach_bin5");
        check("s4_tmo_before", 64'(TmoErr), 64'(0));
        wait_frames(1, 500, "s4_frame");
        hang_en = 1'b0;
        repeat (10) @(negedge Clock);
        check("s4_tmo_sticky", 64'(TmoErr), 64'(1));

        // ConvBusy held 4 cycles in LAUNCH of bin 3: start delayed, ConvIn stable.
        push_frame(CH_R, -1, 3);
        pulse_req(1'b0, 1'b1);
        wait_state(ST_LAUNCH, 3, 200, "s5_reach_launch");
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            check("s5_stall_state", 64'(dbg_state), 64'(ST_LAUNCH));
            check("s5_no_start", 64'(ConvStart), 64'(0));
        end
        check("s5_conv_in", 64'(ConvIn), 64'(mag_of(1'b1, 5'd3)));
        force_busy = 1'b0;
        @(negedge Clock);
        check("s5_start", 64'(ConvStart), 64'(1));
        wait_frames(1, 400, "s5_frame");

        // Reset during WAIT of bin 17: outputs clear at once, no write follows.
        push_frame(CH_L, -1, -1);
        pulse_req(1'b1, 1'b0);
        wait_state(ST_WAIT, 17, 300, "s6_reach_bin17");
        Reset = 1'b1;
        #1;
        check_outputs_zero("s6_async_reset");
        exp_q.delete();
        done_q.delete();
        repeat (4) @(negedge Clock);
        Reset = 1'b0;
        repeat (4) @(negedge Clock);
        check("s6_stay_idle", 64'(dbg_state), 64'(ST_IDLE));
        push_frame(CH_L, -1, -1);
        pulse_req(1'b1, 1'b0);
        wait_frames(1, 400, "s6_restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
